// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master data bus arbiter.
package bus_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam logic        OWNER_CPU = 1'b0;
  localparam logic        OWNER_EXT = 1'b1;
  localparam logic [31:0] ERR_RDATA = 32'h0;
  localparam logic [3:0]  BE_NONE   = 4'b0;

endpackage

// File: rtl/bus_arb_timer.sv
// Transaction watchdog: cleared on grant, counts while enabled, saturates at TIMEOUT-1.
module bus_arb_timer #(
  parameter int          CNT_W   = 9,
  parameter logic [15:0] TIMEOUT = 16'd256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 16'd1);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = (r_cnt == LAST);

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one multi-cycle slave port between the CPU data port (M0)
// and a req/done loader master (M1); one outstanding transaction, watchdog-terminated.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'd256,
  parameter int          CNT_W   = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_re,
  input  logic [3:0]  m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_stall,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_re,
  input  logic [3:0]  m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        s_req,
  output logic        s_re,
  output logic [3:0]  s_we,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_ready
);

  arb_state_e  r_state, w_state_nxt;
  logic        r_owner, r_last_owner, r_m0_done_q;
  logic        w_m0_req, w_grant, w_grant_owner, w_complete, w_expire, w_busy;
  logic [31:0] w_rdata_cap;
  logic        w_err_cap;

  // The done flag masks the still-asserted CPU request for the one cycle the core advances.
  assign w_m0_req = (m0_re | (|m0_we)) & ~r_m0_done_q;
  assign m0_stall = w_m0_req;
  assign w_busy   = (r_state == BUSY);
  assign m1_gnt   = w_busy && (r_owner == OWNER_EXT);

  assign w_rdata_cap = (s_ready && (s_we == BE_NONE)) ? s_rdata : ERR_RDATA;
  assign w_err_cap   = ~s_ready;

  bus_arb_timer #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_grant),
    .i_enable (w_busy),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant       = 1'b0;
    w_grant_owner = OWNER_CPU;
    w_complete    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_m0_req && m1_req) begin
          w_grant       = 1'b1;
          w_grant_owner = ~r_last_owner;
        end else if (w_m0_req) begin
          w_grant       = 1'b1;
          w_grant_owner = OWNER_CPU;
        end else if (m1_req) begin
          w_grant       = 1'b1;
          w_grant_owner = OWNER_EXT;
        end
        if (w_grant) w_state_nxt = BUSY;
      end
      BUSY: begin
        w_complete = s_ready | w_expire;
        if (w_complete) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= OWNER_CPU;
      r_last_owner <= OWNER_EXT;
      r_m0_done_q  <= 1'b0;
      s_req        <= 1'b0;
      s_re         <= 1'b0;
      s_we         <= BE_NONE;
      s_addr       <= '0;
      s_wdata      <= '0;
      m0_rdata     <= '0;
      m0_err       <= 1'b0;
      m1_rdata     <= '0;
      m1_err       <= 1'b0;
      m1_done      <= 1'b0;
    end else begin
      r_m0_done_q <= 1'b0;
      m1_done     <= 1'b0;
      if (w_grant) begin
        r_owner <= w_grant_owner;
        s_req   <= 1'b1;
        if (w_grant_owner == OWNER_CPU) begin
          s_re    <= m0_re;
          s_we    <= m0_we;
          s_addr  <= m0_addr;
          s_wdata <= m0_wdata;
        end else begin
          s_re    <= m1_re;
          s_we    <= m1_we;
          s_addr  <= m1_addr;
          s_wdata <= m1_wdata;
        end
      end
      if (w_complete) begin
        s_req        <= 1'b0;
        r_last_owner <= r_owner;
        if (r_owner == OWNER_CPU) begin
          r_m0_done_q <= 1'b1;
          m0_rdata    <= w_rdata_cap;
          m0_err      <= w_err_cap;
        end else begin
          m1_done  <= 1'b1;
          m1_rdata <= w_rdata_cap;
          m1_err   <= w_err_cap;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table, arbitration/reset sequences, random traffic.
module tb_bus_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_re;
  logic [3:0]  m0_we;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m0_stall, m0_err;
  logic        m1_req, m1_re;
  logic [3:0]  m1_we;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        m1_gnt, m1_done, m1_err;
  logic        s_req, s_re;
  logic [3:0]  s_we;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        s_ready;

  bus_arbiter #(.TIMEOUT(16'd16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_re(m0_re), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_stall(m0_stall), .m0_err(m0_err),
    .m1_req(m1_req), .m1_re(m1_re), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_req(s_req), .s_re(s_re), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Slave model: ready on the (delay+1)-th cycle s_req is seen high, never if delay < 0.
  typedef struct {
    bit          valid;
    logic        re;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } slv_log_t;

  int          slv_delay = 0;
  logic [31:0] slv_key   = 32'h0;
  int          slv_bc    = 0;
  slv_log_t    slv_log;

  initial begin
    s_ready = 1'b0;
    s_rdata = 32'hBAD0_BAD0;
    slv_log = '{1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    forever begin
      @(posedge clk); #1;
      if (s_req === 1'b1) begin
        s_ready = (slv_delay >= 0) && (slv_bc == slv_delay);
        s_rdata = s_ready ? (s_addr ^ slv_key) : 32'hBAD0_BAD0;
        if (s_ready) slv_log = '{1'b1, s_re, s_we, s_addr, s_wdata};
        slv_bc++;
      end else begin
        s_ready = 1'b0;
        s_rdata = 32'hBAD0_BAD0;
        slv_bc  = 0;
      end
    end
  end

  // Grant-order and done-pulse monitors.
  bit   mon_on   = 1'b0;
  logic order_q[$];
  int   done_cnt = 0;
  logic prev_sreq = 1'b0;

  initial begin
    forever begin
      @(posedge clk); #3;
      if (m1_done === 1'b1) done_cnt++;
      if (mon_on && (s_req === 1'b1) && (prev_sreq !== 1'b1)) order_q.push_back(m1_gnt);
      prev_sreq = s_req;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_slave(input int d, input logic [31:0] key);
    slv_delay     = d;
    slv_key       = key;
    slv_log.valid = 1'b0;
  endtask

  // Called at +1 of a cycle with the CPU request already driven.
  task automatic wait_m0(input string tag, output int lat, output int gnt,
                         output logic [31:0] rdata, output logic err);
    bit ok = 1'b0;
    lat = 0;
    gnt = 0;
    #2;
    for (int i = 0; i < 200; i++) begin
      if (m0_stall === 1'b0) begin
        ok = 1'b1;
        break;
      end
      lat++;
      if (m1_gnt === 1'b1) gnt++;
      @(posedge clk); #3;
    end
    if (!ok) fail_bound(tag);
    rdata = m0_rdata;
    err   = m0_err;
  endtask

  task automatic m0_txn(input logic re, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output int gnt,
                        output logic [31:0] rdata, output logic err);
    @(posedge clk); #1;
    m0_re    = re;
    m0_we    = we;
    m0_addr  = addr;
    m0_wdata = wdata;
    wait_m0("m0_wait", lat, gnt, rdata, err);
  endtask

  task automatic m0_release();
    @(posedge clk); #1;
    m0_re = 1'b0;
    m0_we = 4'h0;
  endtask

  task automatic m1_txn(input logic re, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output int gnt,
                        output logic [31:0] rdata, output logic err);
    bit ok = 1'b0;
    lat   = 0;
    gnt   = 0;
    rdata = 32'h0;
    err   = 1'b0;
    @(posedge clk); #1;
    m1_req   = 1'b1;
    m1_re    = re;
    m1_we    = we;
    m1_addr  = addr;
    m1_wdata = wdata;
    #2;
    for (int i = 0; i < 200; i++) begin
      lat++;
      if (m1_gnt === 1'b1) gnt++;
      if (m1_done === 1'b1) begin
        ok     = 1'b1;
        rdata  = m1_rdata;
        err    = m1_err;
        m1_req = 1'b0;
        m1_re  = 1'b0;
        m1_we  = 4'h0;
        break;
      end
      @(posedge clk); #3;
    end
    if (!ok) begin
      fail_bound("m1_wait");
      m1_req = 1'b0;
    end else begin
      @(posedge clk); #3;
      check("m1_done_pulse", {31'h0, m1_done}, 32'h0);
    end
  endtask

  typedef struct {
    bit          is_m1;
    logic        re;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] sdata;
    int          delay;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_gnt;
  } vec_t;

  vec_t vecs[9];

  int          la, ga, lb, gb, lat, gnt, done_before;
  logic [31:0] rda, rdb, rd;
  logic        ea, eb, er;

  initial begin
    // is_m1 re we addr wdata s_rdata delay | rdata err latency gnt_cycles
    vecs[0] = '{1'b0, 1'b1, 4'h0, 32'h1000_0000, 32'h0,         32'hDEADBEEF,  0, 32'hDEADBEEF, 1'b0,  2,  0};
    vecs[1] = '{1'b1, 1'b0, 4'h1, 32'h1000_0004, 32'h0000_00A5, 32'h1234_5678, 0, 32'h0,        1'b0,  3,  1};
    vecs[2] = '{1'b0, 1'b1, 4'h0, 32'h1000_0010, 32'h0,         32'h5555_5555, -1, 32'h0,       1'b1, 17,  0};
    vecs[3] = '{1'b0, 1'b1, 4'h0, 32'h1000_0020, 32'h0,         32'hCAFE_F00D, 15, 32'hCAFEF00D, 1'b0, 17, 0};
    vecs[4] = '{1'b1, 1'b1, 4'h0, 32'h2000_0000, 32'h0,         32'h0BAD_CAFE, 3, 32'h0BADCAFE, 1'b0,  6,  4};
    vecs[5] = '{1'b1, 1'b1, 4'h0, 32'h2000_0004, 32'h0,         32'h7777_7777, -1, 32'h0,       1'b1, 18, 16};
    vecs[6] = '{1'b0, 1'b0, 4'hF, 32'h3000_0000, 32'h0102_0304, 32'h9999_9999, 2, 32'h0,        1'b0,  4,  0};
    vecs[7] = '{1'b1, 1'b1, 4'h0, 32'h2000_0008, 32'h0,         32'h1357_9BDF, 14, 32'h13579BDF, 1'b0, 17, 15};
    vecs[8] = '{1'b0, 1'b1, 4'h0, 32'h1000_0030, 32'h0,         32'h4444_4444, 16, 32'h0,       1'b1, 17,  0};

    rst_n = 1'b0;
    m0_re = 1'b0; m0_we = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_re = 1'b0; m1_we = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;

    repeat (2) @(posedge clk);
    #3;
    check("rst_s_req",    {31'h0, s_req},    32'h0);
    check("rst_s_re",     {31'h0, s_re},     32'h0);
    check("rst_s_we",     {28'h0, s_we},     32'h0);
    check("rst_s_addr",   s_addr,            32'h0);
    check("rst_s_wdata",  s_wdata,           32'h0);
    check("rst_m1_gnt",   {31'h0, m1_gnt},   32'h0);
    check("rst_m1_done",  {31'h0, m1_done},  32'h0);
    check("rst_m0_stall", {31'h0, m0_stall}, 32'h0);
    check("rst_m0_rdata", m0_rdata,          32'h0);
    check("rst_m0_err",   {31'h0, m0_err},   32'h0);
    check("rst_m1_rdata", m1_rdata,          32'h0);
    check("rst_m1_err",   {31'h0, m1_err},   32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Simultaneous requests right after reset: M0 wins, M1 slips in during the CPU's
    // advance cycle, then the CPU's back-to-back request follows.
    set_slave(0, 32'h0F0F_0F0F);
    order_q.delete();
    mon_on = 1'b1;
    fork
      begin
        m0_txn(1'b1, 4'h0, 32'h4000_0000, 32'h0, la, ga, rda, ea);
        check("confA_m0a_rdata", rda, 32'h4F0F_0F0F);
        m0_txn(1'b1, 4'h0, 32'h4000_0008, 32'h0, la, ga, rda, ea);
        check("confA_m0b_rdata", rda, 32'h4F0F_0F07);
        m0_release();
      end
      begin
        m1_txn(1'b1, 4'h0, 32'h5000_0000, 32'h0, lb, gb, rdb, eb);
        check("confA_m1_rdata", rdb, 32'h5F0F_0F0F);
      end
    join
    check("confA_count", order_q.size(), 32'd3);
    check("confA_first",  {31'h0, order_q[0]}, 32'h0);
    check("confA_second", {31'h0, order_q[1]}, 32'h1);
    check("confA_third",  {31'h0, order_q[2]}, 32'h0);

    // Last owner was M0, so the next tie goes to M1.
    order_q.delete();
    fork
      begin
        m0_txn(1'b1, 4'h0, 32'h4000_0010, 32'h0, la, ga, rda, ea);
        m0_release();
      end
      m1_txn(1'b1, 4'h0, 32'h5000_0010, 32'h0, lb, gb, rdb, eb);
    join
    check("confB_count",  order_q.size(), 32'd2);
    check("confB_first",  {31'h0, order_q[0]}, 32'h1);
    check("confB_second", {31'h0, order_q[1]}, 32'h0);
    check("confB_m0_rdata", rda, 32'h4F0F_0F1F);
    mon_on = 1'b0;

    for (int i = 0; i < 9; i++) begin
      set_slave(vecs[i].delay, vecs[i].sdata ^ vecs[i].addr);
      if (vecs[i].is_m1) begin
        m1_txn(vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, gnt, rd, er);
      end else begin
        m0_txn(vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, gnt, rd, er);
        m0_release();
      end
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_gnt_cycles", i), gnt, vecs[i].exp_gnt);
      if (!vecs[i].exp_err) begin
        check($sformatf("vec%0d_slv_seen", i), {31'h0, slv_log.valid}, 32'h1);
        check($sformatf("vec%0d_slv_addr", i), slv_log.addr, vecs[i].addr);
        check($sformatf("vec%0d_slv_we", i), {28'h0, slv_log.we}, {28'h0, vecs[i].we});
        check($sformatf("vec%0d_slv_wdata", i), slv_log.wdata, vecs[i].wdata);
        check($sformatf("vec%0d_slv_re", i), {31'h0, slv_log.re}, {31'h0, vecs[i].re});
      end
    end

    // Reset while M1 is mid-transaction with a CPU request pending behind it.
    set_slave(-1, 32'h0);
    done_before = done_cnt;
    @(posedge clk); #1;
    m1_req = 1'b1; m1_re = 1'b1; m1_we = 4'h0; m1_addr = 32'h6000_0000;
    @(posedge clk); #1;
    m0_re = 1'b1; m0_we = 4'h0; m0_addr = 32'h7000_0000;
    @(posedge clk); #3;
    check("rstb_gnt_before",   {31'h0, m1_gnt},   32'h1);
    check("rstb_stall_before", {31'h0, m0_stall}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstb_s_req",   {31'h0, s_req},    32'h0);
    check("rstb_m1_gnt",  {31'h0, m1_gnt},   32'h0);
    check("rstb_m1_done", {31'h0, m1_done},  32'h0);
    check("rstb_m1_err",  {31'h0, m1_err},   32'h0);
    check("rstb_stall",   {31'h0, m0_stall}, 32'h1);
    m1_req = 1'b0; m1_re = 1'b0;
    @(posedge clk); #1;
    set_slave(0, 32'h3C3C_3C3C);
    rst_n = 1'b1;
    wait_m0("rstb_m0_wait", lat, gnt, rd, er);
    check("rstb_m0_latency", lat, 32'd2);
    check("rstb_m0_rdata", rd, 32'h4C3C_3C3C);
    check("rstb_m0_err", {31'h0, er}, 32'h0);
    m0_release();
    repeat (3) @(posedge clk);
    #3;
    check("rstb_no_m1_done", done_cnt, done_before);

    // Random traffic against a rule-level model of outcome, latency and grant time.
    for (int k = 0; k < 40; k++) begin
      bit          is_m1, ok;
      int          sel, d, exp_lat, exp_gnt;
      logic [3:0]  we;
      logic        re;
      logic [31:0] addr, wdata, key, exp_rd;
      is_m1 = 1'($urandom_range(0, 1));
      sel   = int'($urandom_range(0, 9));
      d     = (sel <= 5) ? sel : (sel == 6) ? -1 : (sel == 7) ? TO - 1 : (sel == 8) ? TO - 2 : TO;
      we    = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      re    = (we == 4'h0);
      addr  = $urandom;
      wdata = $urandom;
      key   = $urandom;
      ok      = (d >= 0) && (d < TO);
      exp_lat = (ok ? d + 2 : TO + 1) + (is_m1 ? 1 : 0);
      exp_gnt = is_m1 ? (ok ? d + 1 : TO) : 0;
      exp_rd  = (ok && (we == 4'h0)) ? (addr ^ key) : 32'h0;
      set_slave(d, key);
      if (is_m1) begin
        m1_txn(re, we, addr, wdata, lat, gnt, rd, er);
      end else begin
        m0_txn(re, we, addr, wdata, lat, gnt, rd, er);
        m0_release();
      end
      check($sformatf("rnd%0d_rdata", k), rd, exp_rd);
      check($sformatf("rnd%0d_err", k), {31'h0, er}, {31'h0, ~ok});
      check($sformatf("rnd%0d_latency", k), lat, exp_lat);
      check($sformatf("rnd%0d_gnt_cycles", k), gnt, exp_gnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
